// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control path.
// Holds the opcode and funct encodings, the ALUOp encodings, the ALU control
// codes, and the state type of the multicycle controller.
// The single-cycle decoder and the multicycle controller both use it.
package mips_pkg;

   // Opcodes, IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct field, IR[5:0]
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // ALU control codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALUOp: the coarse operation chosen by the main controller
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_NONE  = 2'b11
   } aluop_t;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEXE = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder. This block is purely combinational.
// It maps the controller's ALUOp, and for ALUOp=10 also the funct field,
// to the 3-bit ALU operation.
// Ports:
//   aluop       in  2  ALUOp from the main controller
//   iFunct      in  6  funct field, IR[5:0]
//   oALUControl out 3  ALU operation
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] iFunct,
   output logic [2:0] oALUControl
);

   always_comb begin
      oALUControl = ALU_AND;
      case (aluop)
         ALUOP_ADD: oALUControl = ALU_ADD;
         ALUOP_SUB: oALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (iFunct)
               FUNCT_ADD: oALUControl = ALU_ADD;
               FUNCT_SUB: oALUControl = ALU_SUB;
               FUNCT_AND: oALUControl = ALU_AND;
               FUNCT_OR:  oALUControl = ALU_OR;
               FUNCT_SLT: oALUControl = ALU_SLT;
               default:   oALUControl = ALU_AND;
            endcase
         end
         default: oALUControl = ALU_AND;  // ALUOp 11 is unused
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the shared multicycle MIPS datapath.
// Supported instructions: lw, sw, R-type, beq, addi and j.
// Memory accesses wait on iMemReady.
// Ports:
//   iClk, iReset           clock (rising edge), synchronous active-high reset
//   iOp, iFunct            opcode and funct from the instruction register
//   iMemReady              the current memory access completes this cycle
//   oIorD .. oBranch       datapath mux selects and write strobes
// The outputs are decoded from the state alone, with two exceptions.
// The memory strobes (FETCH IRWrite/PCWrite, MEMWR MemWrite) follow iMemReady.
// Reset overrides every output so that nothing is written while it is held.
module multicycle_controller
   import mips_pkg::*;
(
   input  logic       iClk,
   input  logic       iReset,
   input  logic [5:0] iOp,
   input  logic [5:0] iFunct,
   input  logic       iMemReady,
   output logic       oIorD,
   output logic       oMemWrite,
   output logic       oIRWrite,
   output logic       oRegDst,
   output logic       oMemtoReg,
   output logic       oRegWrite,
   output logic       oALUSrcA,
   output logic [1:0] oALUSrcB,
   output logic [2:0] oALUControl,
   output logic [1:0] oPCSrc,
   output logic       oPCWrite,
   output logic       oBranch
);

   state_t state_reg, state_next;
   aluop_t aluop;

   always_ff @(posedge iClk) begin
      if (iReset) state_reg <= FETCH;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      aluop      = ALUOP_ADD;
      oIorD      = 1'b0;
      oMemWrite  = 1'b0;
      oIRWrite   = 1'b0;
      oRegDst    = 1'b0;
      oMemtoReg  = 1'b0;
      oRegWrite  = 1'b0;
      oALUSrcA   = 1'b0;
      oALUSrcB   = 2'b00;
      oPCSrc     = 2'b00;
      oPCWrite   = 1'b0;
      oBranch    = 1'b0;

      case (state_reg)
         FETCH: begin
            oALUSrcB = 2'b01;          // PC + 4
            oIRWrite = iMemReady;
            oPCWrite = iMemReady;
            if (iMemReady) state_next = DECODE;
         end
         DECODE: begin
            oALUSrcB = 2'b11;          // branch target into ALUOut
            case (iOp)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
               OP_ADDI:      state_next = ADDIEXE;
               OP_J:         state_next = JUMP;
               default:      state_next = FETCH;   // illegal opcode: drop it
            endcase
         end
         MEMADR: begin
            oALUSrcA   = 1'b1;
            oALUSrcB   = 2'b10;
            state_next = (iOp == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            oIorD = 1'b1;
            if (iMemReady) state_next = MEMWB;
         end
         MEMWB: begin
            oMemtoReg  = 1'b1;
            oRegWrite  = 1'b1;
            state_next = FETCH;
         end
         MEMWR: begin
            oIorD     = 1'b1;
            oMemWrite = iMemReady;
            if (iMemReady) state_next = FETCH;
         end
         EXECUTE: begin
            oALUSrcA   = 1'b1;
            aluop      = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            oRegDst    = 1'b1;
            oRegWrite  = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            oALUSrcA   = 1'b1;
            aluop      = ALUOP_SUB;
            oPCSrc     = 2'b01;
            oBranch    = 1'b1;
            state_next = FETCH;
         end
         ADDIEXE: begin
            oALUSrcA   = 1'b1;
            oALUSrcB   = 2'b10;
            state_next = ADDIWB;
         end
         ADDIWB: begin
            oRegWrite  = 1'b1;
            state_next = FETCH;
         end
         JUMP: begin
            oPCSrc     = 2'b10;
            oPCWrite   = 1'b1;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase

      // Reset may arrive in any state.
      // While it is held, present FETCH selects and suppress every strobe.
      // The in-flight instruction then has no further architectural effect.
      if (iReset) begin
         state_next = FETCH;
         aluop      = ALUOP_ADD;
         oIorD      = 1'b0;
         oMemWrite  = 1'b0;
         oIRWrite   = 1'b0;
         oRegDst    = 1'b0;
         oMemtoReg  = 1'b0;
         oRegWrite  = 1'b0;
         oALUSrcA   = 1'b0;
         oALUSrcB   = 2'b01;
         oPCSrc     = 2'b00;
         oPCWrite   = 1'b0;
         oBranch    = 1'b0;
      end
   end

   alu_decoder u_alu_decoder (
      .aluop       (aluop),
      .iFunct      (iFunct),
      .oALUControl (oALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller.
// Each instruction is expanded from its cycle-by-cycle control recipe into a
// queue of expected control words, one per cycle, stall cycles included.
// The DUT outputs are compared against that queue on the falling edge.
module tb_multicycle_controller;

   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluctl;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
   } ctl_t;

   logic       iClk = 1'b0;
   logic       iReset;
   logic [5:0] iOp;
   logic [5:0] iFunct;
   logic       iMemReady;
   logic       oIorD, oMemWrite, oIRWrite, oRegDst, oMemtoReg, oRegWrite;
   logic       oALUSrcA, oPCWrite, oBranch;
   logic [1:0] oALUSrcB, oPCSrc;
   logic [2:0] oALUControl;

   multicycle_controller dut (
      .iClk        (iClk),
      .iReset      (iReset),
      .iOp         (iOp),
      .iFunct      (iFunct),
      .iMemReady   (iMemReady),
      .oIorD       (oIorD),
      .oMemWrite   (oMemWrite),
      .oIRWrite    (oIRWrite),
      .oRegDst     (oRegDst),
      .oMemtoReg   (oMemtoReg),
      .oRegWrite   (oRegWrite),
      .oALUSrcA    (oALUSrcA),
      .oALUSrcB    (oALUSrcB),
      .oALUControl (oALUControl),
      .oPCSrc      (oPCSrc),
      .oPCWrite    (oPCWrite),
      .oBranch     (oBranch)
   );

   always #5 iClk = ~iClk;

   ctl_t obs;
   assign obs = '{iord: oIorD, memwrite: oMemWrite, irwrite: oIRWrite,
                  regdst: oRegDst, memtoreg: oMemtoReg, regwrite: oRegWrite,
                  alusrca: oALUSrcA, alusrcb: oALUSrcB, aluctl: oALUControl,
                  pcsrc: oPCSrc, pcwrite: oPCWrite, branch: oBranch};

   int checks = 0;
   int passes = 0;

   logic  ready_q[$];
   ctl_t  exp_q[$];
   string name_q[$];

   // ALU operation that an instruction's arithmetic step asks for
   function automatic logic [2:0] rtype_op(input logic [5:0] f);
      if      (f == 6'b100000) return 3'b010;   // add
      else if (f == 6'b100010) return 3'b110;   // sub
      else if (f == 6'b100100) return 3'b000;   // and
      else if (f == 6'b100101) return 3'b001;   // or
      else if (f == 6'b101010) return 3'b111;   // slt
      else                     return 3'b000;
   endfunction

   // Idle control word: everything off, and the ALU adds (ALUOp 00)
   function automatic ctl_t idle();
      ctl_t e = '0;
      e.aluctl = 3'b010;
      return e;
   endfunction

   function automatic ctl_t reset_word();
      ctl_t e = idle();
      e.alusrcb = 2'b01;
      return e;
   endfunction

   task automatic push(input logic rdy, input ctl_t e, input string nm);
      ready_q.push_back(rdy);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic check(input string tag, input ctl_t got, input ctl_t want);
      checks++;
      assert (got === want) passes++;
      else $error("FAIL %s: got %b required %b", tag, got, want);
   endtask

   // Build the expected per-cycle behaviour of one instruction
   task automatic build(input logic [5:0] op, input logic [5:0] f,
                        input int fstall, input int mstall);
      ctl_t e;
      ready_q.delete(); exp_q.delete(); name_q.delete();
      // instruction fetch, PC += 4, held off until memory is ready
      for (int s = 0; s < fstall; s++) begin
         e = idle(); e.alusrcb = 2'b01; push(1'b0, e, "FETCH-stall");
      end
      e = idle(); e.alusrcb = 2'b01; e.irwrite = 1; e.pcwrite = 1;
      push(1'b1, e, "FETCH");
      // decode: PC + (imm<<2) into ALUOut
      e = idle(); e.alusrcb = 2'b11; push(1'($urandom), e, "DECODE");
      if (op == 6'b100011 || op == 6'b101011) begin
         e = idle(); e.alusrca = 1; e.alusrcb = 2'b10;
         push(1'($urandom), e, "MEMADR");
         for (int s = 0; s < mstall; s++) begin
            e = idle(); e.iord = 1;
            push(1'b0, e, (op == 6'b100011) ? "MEMRD-stall" : "MEMWR-stall");
         end
         if (op == 6'b100011) begin
            e = idle(); e.iord = 1; push(1'b1, e, "MEMRD");
            e = idle(); e.memtoreg = 1; e.regwrite = 1;
            push(1'($urandom), e, "MEMWB");
         end else begin
            e = idle(); e.iord = 1; e.memwrite = 1; push(1'b1, e, "MEMWR");
         end
      end else if (op == 6'b000000) begin
         e = idle(); e.alusrca = 1; e.alusrcb = 2'b00; e.aluctl = rtype_op(f);
         push(1'($urandom), e, "EXECUTE");
         e = idle(); e.regdst = 1; e.regwrite = 1;
         push(1'($urandom), e, "ALUWB");
      end else if (op == 6'b000100) begin
         e = idle(); e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01;
         e.branch = 1;
         push(1'($urandom), e, "BRANCH");
      end else if (op == 6'b001000) begin
         e = idle(); e.alusrca = 1; e.alusrcb = 2'b10;
         push(1'($urandom), e, "ADDIEXE");
         e = idle(); e.regwrite = 1; push(1'($urandom), e, "ADDIWB");
      end else if (op == 6'b000010) begin
         e = idle(); e.pcsrc = 2'b10; e.pcwrite = 1;
         push(1'($urandom), e, "JUMP");
      end
   endtask

   // Run one instruction. If abort_at > 0, reset is asserted after that many
   // cycles and held for two cycles.
   task automatic run(input int n, input logic [5:0] op, input logic [5:0] f,
                      input int fstall, input int mstall, input int abort_at);
      int cycles;
      int fails0;
      build(op, f, fstall, mstall);
      cycles = exp_q.size();
      if (abort_at > 0 && abort_at < cycles) cycles = abort_at;
      fails0 = checks - passes;
      iOp = op; iFunct = f;
      for (int i = 0; i < cycles; i++) begin
         iMemReady = ready_q[i];
         @(negedge iClk);
         check($sformatf("txn%0d %s c%0d", n, name_q[i], i), obs, exp_q[i]);
         @(posedge iClk); #1;
      end
      if (cycles < exp_q.size()) begin
         iReset = 1'b1;
         for (int i = 0; i < 2; i++) begin
            iMemReady = 1'($urandom);
            @(negedge iClk);
            check($sformatf("txn%0d reset-abort c%0d", n, i), obs, reset_word());
            @(posedge iClk); #1;
         end
         iReset = 1'b0;
      end
      $display("txn %0d op=%b funct=%b fstall=%0d mstall=%0d cycles=%0d%s errors=%0d",
               n, op, f, fstall, mstall, cycles,
               (cycles < exp_q.size()) ? " reset-abort" : "",
               (checks - passes) - fails0);
   endtask

   function automatic logic [5:0] rand_funct();
      logic [5:0] legal [5] = '{6'b100000, 6'b100010, 6'b100100,
                                6'b100101, 6'b101010};
      if ($urandom_range(0, 5) == 0) return 6'($urandom);
      return legal[$urandom_range(0, 4)];
   endfunction

   function automatic logic [5:0] rand_op();
      logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000,
                              6'b000100, 6'b001000, 6'b000010};
      logic [5:0] o;
      if ($urandom_range(0, 7) != 0) return ops[$urandom_range(0, 5)];
      do o = 6'($urandom);
      while (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
             o == 6'b000100 || o == 6'b001000 || o == 6'b000010);
      return o;
   endfunction

   initial begin
      iReset = 1'b1; iMemReady = 1'b1; iOp = 6'b100011; iFunct = 6'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge iClk);
         check($sformatf("reset c%0d", i), obs, reset_word());
      end
      @(posedge iClk); #1;
      iReset = 1'b0;

      // directed steps
      run(0, 6'b100011, 6'b000000, 0, 0, 0);   // lw, 5 cycles
      run(1, 6'b000000, 6'b100010, 0, 0, 0);   // sub, 4 cycles
      run(2, 6'b101011, 6'b000000, 0, 3, 0);   // sw with 3 stalls in MEMWR
      run(3, 6'b001000, 6'b000000, 2, 0, 0);   // addi with 2 FETCH stalls
      run(4, 6'b000100, 6'b000000, 0, 0, 0);   // beq, 3 cycles
      run(5, 6'b000010, 6'b000000, 0, 0, 0);   // j, 3 cycles
      run(6, 6'b111111, 6'b000000, 0, 0, 0);   // illegal opcode
      run(7, 6'b100011, 6'b000000, 0, 2, 4);   // reset mid-MEMRD
      run(8, 6'b100011, 6'b000000, 0, 0, 0);   // normal after reset

      // randomized instruction stream
      for (int n = 9; n < 80; n++) begin
         int abort_at;
         logic [5:0] op;
         op = rand_op();
         abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 0;
         run(n, op, rand_funct(), $urandom_range(0, 2), $urandom_range(0, 3),
             abort_at);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
